// File: rtl/demux_pkg.sv
// Shared constants, slot state encoding and a constant clog2 helper for the
// stream demultiplexer.
package demux_pkg;

   localparam int MAX_CH     = 16;
   localparam int DROP_CNT_W = 8;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register slice: holds a word until the consumer takes it,
// optionally clearing the data register when the slot drains.
module demux_out_slot
   import demux_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter bit ZERO_IDLE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] data_in,
   input  logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] data_out,
   output slot_state_t       state
);

   slot_state_t       state_next;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SLOT_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // load is only raised by the parent when the slot can accept, so a FULL
   // slot seeing load is always draining in the same cycle.
   always_comb begin
      state_next = state;
      case (state)
         SLOT_EMPTY: if (load) state_next = SLOT_FULL;
         SLOT_FULL: begin
            if (load) begin
               state_next = SLOT_FULL;
            end else if (ready) begin
               state_next = SLOT_EMPTY;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (load) begin
         data_q <= data_in;
      end else if (ZERO_IDLE && (state == SLOT_FULL) && ready) begin
         data_q <= '0;
      end
   end

   assign valid    = (state == SLOT_FULL);
   assign data_out = data_q;

endmodule

// File: rtl/stream_demux.sv
// 1:NUM_CH valid/ready demultiplexer with a registered slot per channel and a
// saturating counter of words dropped for an out-of-range select.
module stream_demux
   import demux_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NUM_CH    = 4,
   parameter int SEL_W     = 4,
   parameter bit ZERO_IDLE = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [DROP_CNT_W-1:0]    drop_cnt,
   output logic                     sel_err,
   input  logic                     clr_err
);

   // Wide enough to hold both any select value and NUM_CH itself (16 needs 5 bits).
   localparam int CMP_W = (SEL_W > clog2(MAX_CH + 1)) ? SEL_W : clog2(MAX_CH + 1);

   logic              sel_legal;
   logic              sel_ready;
   logic              acc;
   logic              drop;
   logic [NUM_CH-1:0] load;
   slot_state_t       slot_state [NUM_CH];

   assign sel_legal = CMP_W'(in_sel) < CMP_W'(NUM_CH);

   // Pass-through ready: a slot draining this cycle can be refilled on the same edge.
   always_comb begin
      sel_ready = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
         if (sel_legal && (CMP_W'(in_sel) == CMP_W'(k))) begin
            sel_ready = (slot_state[k] == SLOT_EMPTY) || out_ready[k];
         end
      end
   end

   assign in_ready = rst_n && sel_ready;
   assign acc      = in_valid && in_ready;
   assign drop     = acc && !sel_legal;

   always_comb begin
      load = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         load[k] = acc && sel_legal && (CMP_W'(in_sel) == CMP_W'(k));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
         sel_err  <= 1'b0;
      end else if (clr_err) begin
         drop_cnt <= '0;
         sel_err  <= 1'b0;
      end else if (drop) begin
         sel_err <= 1'b1;
         if (drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      demux_out_slot #(
         .DATA_W    (DATA_W),
         .ZERO_IDLE (ZERO_IDLE)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (load[k]),
         .data_in  (in_data),
         .ready    (out_ready[k]),
         .valid    (out_valid[k]),
         .data_out (out_data[k*DATA_W +: DATA_W]),
         .state    (slot_state[k])
      );
   end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-channel zeroing instance driven from a vector
// table and random stimulus against a slot model, plus a 3-channel holding instance.
module tb_stream_demux;

   logic clk = 1'b0;
   logic rst_n;

   logic [7:0]  in_data4;
   logic [3:0]  in_sel4;
   logic        in_valid4;
   logic        in_ready4;
   logic [31:0] out_data4;
   logic [3:0]  out_valid4;
   logic [3:0]  out_ready4;
   logic [7:0]  drop_cnt4;
   logic        sel_err4;
   logic        clr_err4;

   logic [7:0]  in_data3;
   logic [1:0]  in_sel3;
   logic        in_valid3;
   logic        in_ready3;
   logic [23:0] out_data3;
   logic [2:0]  out_valid3;
   logic [2:0]  out_ready3;
   logic [7:0]  drop_cnt3;
   logic        sel_err3;
   logic        clr_err3;

   stream_demux #(.DATA_W(8), .NUM_CH(4), .SEL_W(4), .ZERO_IDLE(1'b1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_sel(in_sel4),
      .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
      .out_valid(out_valid4), .out_ready(out_ready4), .drop_cnt(drop_cnt4),
      .sel_err(sel_err4), .clr_err(clr_err4)
   );

   stream_demux #(.DATA_W(8), .NUM_CH(3), .SEL_W(2), .ZERO_IDLE(1'b0)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel3),
      .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
      .out_valid(out_valid3), .out_ready(out_ready3), .drop_cnt(drop_cnt3),
      .sel_err(sel_err3), .clr_err(clr_err3)
   );

   always #5 clk = ~clk;

   int n_cmp;
   int n_err;

   // Reference model of the 4-channel instance: queue front is the word in the slot.
   logic [3:0] model_full;
   logic [7:0] exp_q [4][$];
   int         model_drop;

   typedef struct {
      logic       valid;
      logic [3:0] sel;
      logic [7:0] data;
      logic [3:0] rdy;
      logic       exp_ready;
   } vec_t;

   vec_t vecs [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input logic v, input logic [3:0] s, input logic [7:0] d,
                          input logic [3:0] r, input logic e);
      vec_t t;
      t.valid     = v;
      t.sel       = s;
      t.data      = d;
      t.rdy       = r;
      t.exp_ready = e;
      vecs.push_back(t);
   endtask

   task automatic model_reset();
      model_full = '0;
      model_drop = 0;
      for (int k = 0; k < 4; k++) exp_q[k].delete();
   endtask

   // Compare the 4-channel outputs against the model, then advance the model
   // by what the coming edge will transfer.
   task automatic monitor();
      logic       legal;
      logic       exp_ready;
      logic [1:0] s;
      check("out_valid", 32'(out_valid4), 32'(model_full));
      for (int k = 0; k < 4; k++) begin
         if (model_full[k]) begin
            if (exp_q[k].size() == 0) begin
               check($sformatf("sb_empty_ch%0d", k), 32'(1), 32'(0));
            end else begin
               check($sformatf("out_data_ch%0d", k), 32'(out_data4[k*8 +: 8]), 32'(exp_q[k][0]));
            end
         end else begin
            check($sformatf("idle_zero_ch%0d", k), 32'(out_data4[k*8 +: 8]), 32'(0));
         end
      end
      check("drop_cnt", 32'(drop_cnt4), (model_drop > 255) ? 32'd255 : 32'(model_drop));
      check("sel_err", 32'(sel_err4), 32'(model_drop != 0));
      legal     = in_sel4 < 4'd4;
      s         = in_sel4[1:0];
      exp_ready = legal ? (!model_full[s] || out_ready4[s]) : 1'b1;
      check("in_ready", 32'(in_ready4), 32'(exp_ready));
      for (int k = 0; k < 4; k++) begin
         if (model_full[k] && out_ready4[k]) begin
            if (exp_q[k].size() > 0) void'(exp_q[k].pop_front());
            model_full[k] = 1'b0;
         end
      end
      if (in_valid4 && exp_ready) begin
         if (legal) begin
            exp_q[s].push_back(in_data4);
            model_full[s] = 1'b1;
         end else begin
            model_drop++;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic drive4(input logic v, input logic [3:0] s, input logic [7:0] d, input logic [3:0] r);
      in_valid4  = v;
      in_sel4    = s;
      in_data4   = d;
      out_ready4 = r;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      model_reset();
      rst_n = 1'b0;
      drive4(1'b0, 4'd0, 8'h00, 4'hF);
      clr_err4   = 1'b0;
      in_valid3  = 1'b0;
      in_sel3    = 2'd0;
      in_data3   = 8'h00;
      out_ready3 = 3'b111;
      clr_err3   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready4", 32'(in_ready4), 32'(0));
      check("rst_out_valid4", 32'(out_valid4), 32'(0));
      check("rst_out_data4", out_data4, 32'(0));
      check("rst_drop_cnt4", 32'(drop_cnt4), 32'(0));
      check("rst_in_ready3", 32'(in_ready3), 32'(0));
      check("rst_sel_err3", 32'(sel_err3), 32'(0));
      rst_n = 1'b1;

      // valid, sel, data, out_ready, expected in_ready
      add_vec(1'b1, 4'd0,  8'h11, 4'b1111, 1'b1);
      add_vec(1'b1, 4'd1,  8'h22, 4'b1111, 1'b1);
      add_vec(1'b1, 4'd2,  8'h33, 4'b1111, 1'b1);
      add_vec(1'b1, 4'd3,  8'h44, 4'b1111, 1'b1);
      add_vec(1'b0, 4'd0,  8'h00, 4'b1111, 1'b1);
      add_vec(1'b1, 4'd1,  8'h55, 4'b1101, 1'b1);
      add_vec(1'b1, 4'd1,  8'h66, 4'b1101, 1'b0);
      add_vec(1'b1, 4'd1,  8'h66, 4'b1111, 1'b1);
      add_vec(1'b0, 4'd1,  8'h00, 4'b1111, 1'b1);
      add_vec(1'b1, 4'd0,  8'hA0, 4'b1110, 1'b1);
      add_vec(1'b1, 4'd3,  8'h77, 4'b1110, 1'b1);
      add_vec(1'b1, 4'd0,  8'hB0, 4'b1110, 1'b0);
      add_vec(1'b1, 4'd0,  8'hB0, 4'b1111, 1'b1);
      add_vec(1'b1, 4'd9,  8'hEE, 4'b0000, 1'b1);
      add_vec(1'b0, 4'd0,  8'h00, 4'b0000, 1'b0);
      add_vec(1'b0, 4'd0,  8'h00, 4'b1111, 1'b1);
      add_vec(1'b1, 4'd15, 8'hEF, 4'b1111, 1'b1);

      for (int i = 0; i < vecs.size(); i++) begin
         drive4(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].rdy);
         #1;
         check($sformatf("vec%0d_in_ready", i), 32'(in_ready4), 32'(vecs[i].exp_ready));
         tick();
      end

      for (int i = 0; i < 80; i++) begin
         drive4(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)),
                8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
         tick();
      end

      // Asynchronous reset with channel 2 holding a word.
      drive4(1'b0, 4'd0, 8'h00, 4'b1111);
      tick();
      drive4(1'b1, 4'd2, 8'hA5, 4'b1011);
      tick();
      in_valid4 = 1'b0;
      #1;
      check("pre_rst_valid2", 32'(out_valid4[2]), 32'(1));
      check("pre_rst_data2", 32'(out_data4[23:16]), 32'(8'hA5));
      rst_n = 1'b0;
      #1;
      check("async_out_valid", 32'(out_valid4), 32'(0));
      check("async_out_data", out_data4, 32'(0));
      check("async_in_ready", 32'(in_ready4), 32'(0));
      check("async_drop_cnt", 32'(drop_cnt4), 32'(0));
      check("async_sel_err", 32'(sel_err4), 32'(0));
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive4(1'b1, 4'd3, 8'h3C, 4'b0111);
      tick();
      drive4(1'b0, 4'd3, 8'h00, 4'b0111);
      tick();
      tick();

      // Three-channel instance: illegal select, saturation, clear priority.
      in_valid3 = 1'b1;
      in_sel3   = 2'd3;
      in_data3  = 8'h99;
      #1;
      check("ill_in_ready", 32'(in_ready3), 32'(1));
      @(posedge clk);
      #1;
      check("ill_out_valid", 32'(out_valid3), 32'(0));
      check("ill_drop_cnt", 32'(drop_cnt3), 32'(1));
      check("ill_sel_err", 32'(sel_err3), 32'(1));
      repeat (299) @(posedge clk);
      #1;
      check("sat_drop_cnt", 32'(drop_cnt3), 32'(255));
      check("sat_out_valid", 32'(out_valid3), 32'(0));
      clr_err3 = 1'b1;
      @(posedge clk);
      #1;
      check("clr_drop_cnt", 32'(drop_cnt3), 32'(0));
      check("clr_sel_err", 32'(sel_err3), 32'(0));
      clr_err3  = 1'b0;
      in_valid3 = 1'b0;
      @(posedge clk);
      #1;
      check("post_clr_drop_cnt", 32'(drop_cnt3), 32'(0));

      // Legal word on the holding instance: data stays after drain.
      in_valid3  = 1'b1;
      in_sel3    = 2'd2;
      in_data3   = 8'h5A;
      out_ready3 = 3'b011;
      #1;
      check("hold_in_ready", 32'(in_ready3), 32'(1));
      @(posedge clk);
      #1;
      in_valid3 = 1'b0;
      check("hold_valid_full", 32'(out_valid3), 32'(3'b100));
      check("hold_data_full", 32'(out_data3[23:16]), 32'(8'h5A));
      in_sel3 = 2'd2;
      #1;
      check("hold_blocked_ready", 32'(in_ready3), 32'(0));
      out_ready3 = 3'b111;
      @(posedge clk);
      #1;
      check("hold_valid_empty", 32'(out_valid3), 32'(0));
      check("hold_data_kept", 32'(out_data3[23:16]), 32'(8'h5A));
      check("hold_ch0_data", 32'(out_data3[7:0]), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised 1:NUM_CH demultiplexer for DATA_W-bit words, with a valid/ready handshake on the input and on every output channel.
- Each output channel has a one-entry registered slot, giving one cycle of latency and independent per-channel backpressure.
- Words steered to a nonexistent channel are dropped and counted.
- Successor to the fixed 8-bit 1:2 combinational demux. Sits between a single producer and NUM_CH consumer paths.

Parameters:
- DATA_W, 8: data word width in bits.
- NUM_CH, 4: number of output channels; legal range 2..16.
- SEL_W, 4: width of the select input. Must satisfy 2^SEL_W >= NUM_CH; select values >= NUM_CH are illegal.
- ZERO_IDLE, 1: when 1, out_data of a channel reads all-zero whenever its out_valid is 0. When 0, the last word is held.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  word to route.
- in_sel  input  SEL_W  destination channel index.
- in_valid  input  1  in_data and in_sel are valid.
- in_ready  output  1  block accepts the word this cycle.
- out_data  output  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  output  NUM_CH  per-channel valid.
- out_ready  input  NUM_CH  per-channel consumer ready.
- drop_cnt  output  8  saturating count of dropped illegal-select words.
- sel_err  output  1  sticky flag, set on the first illegal select.
- clr_err  input  1  synchronous clear of drop_cnt and sel_err.

Behaviour:
- Reset (rst_n low, asynchronous): all out_valid = 0, all out_data = 0, drop_cnt = 0, sel_err = 0. in_ready is 0 while rst_n is low.
- Any word held in a slot is discarded on reset. There is no partial-transfer recovery.
- Slot state per channel k: EMPTY (out_valid[k] = 0) or FULL (out_valid[k] = 1).
- Accept condition: acc = in_valid & in_ready.
- in_ready for a legal select (in_sel < NUM_CH) = !out_valid[in_sel] | out_ready[in_sel]. This is a pass-through ready, so a FULL slot that drains this cycle can refill in the same cycle.
- in_ready for an illegal select = 1. The word is always consumed and dropped.
- in_ready depends combinationally on in_sel and out_ready. It must not depend on in_valid.
- Latency: a word accepted at edge N appears on out_data[k] with out_valid[k] = 1 after edge N.
- Slot k transitions:
  - EMPTY -> FULL on acc with in_sel = k.
  - FULL -> EMPTY on out_ready[k] with no acc to k.
  - FULL -> FULL, reloaded with the new word, on out_ready[k] together with acc to k.
  - FULL with out_ready[k] = 0: holds data and valid stable.
- Ordering: at most one slot loads per cycle. Channels drain independently; there is no cross-channel ordering guarantee.
- Output stability: while out_valid[k] = 1 and out_ready[k] = 0, out_data[k] must not change.
- ZERO_IDLE = 1: out_data[k] is forced to 0 whenever out_valid[k] = 0 (registered zeroing, not gated).
- Illegal select, on acc with in_sel >= NUM_CH:
  - drop_cnt increments, saturating at 255.
  - sel_err is set.
  - No slot is modified.
- clr_err has priority over a simultaneous drop. drop_cnt and sel_err read 0 after that edge, and the concurrent drop is not counted.
- in_valid = 0: no state change apart from slots draining.
- in_valid may be held high across cycles with in_ready = 0. The producer must keep in_data and in_sel stable until accepted; the block does not check this.

Decomposition:
- Package demux_pkg holds:
  - A clog2 helper constant function.
  - Constants MAX_CH = 16 and DROP_CNT_W = 8.
  - The slot state encoding (SLOT_EMPTY = 0, SLOT_FULL = 1).
- Sub-module demux_out_slot: a one-entry register slice with load/data_in/ready/valid/data_out and the ZERO_IDLE behaviour.
  - Instantiated NUM_CH times by a generate loop.
  - The top level holds select decode, the in_ready mux and the drop counter.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with slot 2 FULL holding 0xA5 -> out_valid = 0000, out_data all zero, in_ready = 0, drop_cnt = 0 immediately, without waiting for a clock edge.
- Routing (NUM_CH = 4): send 0x11, 0x22, 0x33, 0x44 with sel 0..3 and all out_ready = 1 -> each word appears on its channel one cycle after acceptance; other channels stay valid = 0 and data = 0.
- Backpressure: out_ready[1] = 0, send 0x55 then 0x66 to sel 1 -> second word stalls (in_ready = 0) and out_data[1] holds 0x55. Raise out_ready[1] -> 0x66 loads on that same edge with no bubble.
- Independence: channel 0 blocked and FULL, send 0x77 to sel 3 -> accepted immediately (in_ready = 1); channel 0 is unchanged.
- Illegal select (NUM_CH = 3): send 0x99 with sel 3 -> in_ready = 1, no out_valid rises, drop_cnt = 1, sel_err = 1. After 300 drops, drop_cnt = 255.
- Clear priority: clr_err pulsed together with an illegal-select word -> drop_cnt = 0 and sel_err = 0 after that edge.
